// File: rtl/ibex_multdiv_issue_pkg.sv
// Shared types for the multdiv issue controller: operator encoding, FSM states
// and the registered request bundle handed to the slow multiplier/divider.
package ibex_multdiv_issue_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'b00,
    MD_OP_MULH = 2'b01,
    MD_OP_DIV  = 2'b10,
    MD_OP_REM  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY  = 2'b01,
    DRAIN = 2'b10,
    WB    = 2'b11
  } multdiv_issue_state_e;

  typedef struct packed {
    md_op_e      op;
    logic [1:0]  signed_mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } md_req_t;

  localparam int unsigned MdCntW = 6;

  function automatic logic md_is_div(input md_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/ibex_multdiv_issue.sv
// ID-stage requester for the multi-cycle multiplier/divider: holds operands,
// sequences the enable against the unit's valid, buffers the result for writeback.
module ibex_multdiv_issue
  import ibex_multdiv_issue_pkg::*;
#(
  parameter int unsigned MaxCycles = 40
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [1:0]  operator_i,
  input  logic [1:0]  signed_mode_i,
  input  logic [31:0] rs_a_i,
  input  logic [31:0] rs_b_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        flush_i,
  output logic        ready_o,
  output logic        stall_id_o,
  output logic        mult_en_o,
  output logic        div_en_o,
  output logic [1:0]  md_operator_o,
  output logic [1:0]  md_signed_mode_o,
  output logic [31:0] md_op_a_o,
  output logic [31:0] md_op_b_o,
  input  logic        md_valid_i,
  input  logic [31:0] md_result_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_data_o,
  input  logic        wb_ready_i,
  output logic        timeout_o
);

  localparam logic [MdCntW-1:0] CntLast = MdCntW'(MaxCycles - 1);

  multdiv_issue_state_e state_q, state_d;
  md_req_t              req_q, req_d;
  logic [31:0]          wb_data_q, wb_data_d;
  logic [MdCntW-1:0]    cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;
  logic                 accept, enabled;

  assign ready_o    = ((state_q == IDLE) | ((state_q == WB) & wb_ready_i)) & ~flush_i;
  assign stall_id_o = req_i & ~ready_o;
  assign accept     = req_i & ready_o;
  // DRAIN keeps the enable up: the unit cannot be aborted, only frozen.
  assign enabled    = (state_q == BUSY) | (state_q == DRAIN);

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    wb_data_d = wb_data_q;
    unique case (state_q)
      IDLE: ;
      BUSY: begin
        if (md_valid_i) begin
          if (flush_i) begin
            state_d = IDLE;
          end else begin
            state_d   = WB;
            wb_data_d = md_result_i;
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: if (md_valid_i) state_d = IDLE;
      WB:    if (flush_i || wb_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Accept overrides the IDLE exit of WB so back-to-back ops have no gap.
    if (accept) begin
      state_d = BUSY;
      req_d   = '{op:          md_op_e'(operator_i),
                  signed_mode: signed_mode_i,
                  a:           rs_a_i,
                  b:           rs_b_i,
                  rd:          rd_addr_i};
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = '0;
    end else if (enabled && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
    timeout_d = timeout_q | (enabled & (cnt_q >= CntLast));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      req_q     <= '0;
      wb_data_q <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      wb_data_q <= wb_data_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign mult_en_o        = enabled & ~md_is_div(req_q.op);
  assign div_en_o         = enabled &  md_is_div(req_q.op);
  assign md_operator_o    = req_q.op;
  assign md_signed_mode_o = req_q.signed_mode;
  assign md_op_a_o        = req_q.a;
  assign md_op_b_o        = req_q.b;
  assign wb_valid_o       = (state_q == WB);
  assign wb_addr_o        = req_q.rd;
  assign wb_data_o        = wb_data_q;
  assign timeout_o        = timeout_q;

endmodule
